// File: rtl/dmem_access_unit_if.sv
// Request/response and DMEM port bundle for the data-memory access unit.
// slave: the access unit. master: the CPU memory stage together with the DMEM.
interface dmem_access_unit_if #(
  parameter int unsigned IDX_W = 11
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [1:0]       req_width;
  logic             req_sign;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [IDX_W-1:0] mem_addr;
  logic             mem_wena;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_width, req_sign, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wena, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_width, req_sign, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wena, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Multi-cycle load/store engine in front of a synchronous-read DMEM.
// Word stores write directly, loads read/extract/extend, sub-word stores
// read-modify-write so neighbouring lanes survive.
module dmem_access_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned IDX_W     = 11
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_unit_if.slave  bus
);

  localparam int unsigned RANGE_SH = IDX_W + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t           state;
  logic             we_q;
  logic             sign_q;
  logic [1:0]       width_q;
  logic [1:0]       lane_q;
  logic [31:0]      wdata_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem_wdata_q;

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             below_base;
  logic             out_of_range;
  logic             misaligned;
  logic             req_bad;
  logic             req_word;

  // Address translation and rejection checks on the live request
  always_comb begin
    offset       = bus.req_addr - BASE_ADDR;
    idx          = offset[IDX_W+1:2];
    below_base   = bus.req_addr < BASE_ADDR;
    out_of_range = |(offset >> RANGE_SH);
    req_word     = bus.req_width[1];
    misaligned   = 1'b0;
    if (req_word) begin
      misaligned = |bus.req_addr[1:0];
    end else if (bus.req_width[0]) begin
      misaligned = bus.req_addr[0];
    end
    req_bad = below_base | out_of_range | misaligned;
  end

  // Pick the addressed lane out of a DMEM word and extend it
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [1:0] width, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (width)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of a DMEM word with store data
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [1:0] width, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (width)
      2'b00: r[{lane, 3'b000} +: 8] = d[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = d[15:0];
        else         r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Sequencer: capture in IDLE, then RD/MRG/WR as needed, one-cycle RSP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      width_q     <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= 32'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            sign_q  <= bus.req_sign;
            width_q <= bus.req_width;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            if (req_bad) begin
              err_q <= 1'b1;
              state <= RSP;
            end else begin
              idx_q <= idx;
              if (bus.req_we && req_word) begin
                mem_wdata_q <= bus.req_wdata;
                state       <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= MRG;
        MRG: begin
          if (we_q) begin
            mem_wdata_q <= store_merge(bus.mem_rdata, lane_q, width_q, wdata_q);
            state       <= WR;
          end else begin
            rdata_q <= load_extract(bus.mem_rdata, lane_q, width_q, sign_q);
            state   <= RSP;
          end
        end
        WR: state <= RSP;
        RSP: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decoded straight from registers; reset drops ready and any write at once
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.mem_wena  = (state == WR);
  assign bus.mem_addr  = idx_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a synchronous-read DMEM model.
module tb_dmem_access_unit;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   wr_count = 0;

  dmem_access_unit_if #(.IDX_W(11)) bus();

  dmem_access_unit #(.BASE_ADDR(32'h1001_0000), .IDX_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // DMEM model: synchronous read, preload port for the bench
  logic [31:0] mem [0:2047];
  logic        pre_en = 1'b0;
  logic [10:0] pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (bus.mem_wena) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wena) wr_count <= wr_count + 1;
  end

  // Observations of the last request
  int          o_rsp_cyc, o_rsp_cnt, o_wena_cnt, o_wena_cyc;
  logic        o_rsp_err, o_ready_t0, o_ready_t1;
  logic [31:0] o_rsp_rdata, o_wena_data;
  logic [10:0] o_wena_addr, o_addr_t1;

  task automatic preload(input logic [10:0] i, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = i; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Issue one request, then scramble req_* and watch 6 cycles after accept
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] width, input logic sign);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_width = width; bus.req_sign = sign;
    o_ready_t0 = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_addr = 32'hFFFF_FFFF;
    bus.req_wdata = ~wdata; bus.req_width = ~width; bus.req_sign = ~sign;
    o_rsp_cyc = -1; o_rsp_cnt = 0; o_wena_cnt = 0; o_wena_cyc = -1;
    o_rsp_err = 1'b0; o_rsp_rdata = '0; o_wena_data = '0; o_wena_addr = '0;
    o_ready_t1 = bus.req_ready; o_addr_t1 = bus.mem_addr;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (bus.mem_wena) begin
        if (o_wena_cnt == 0) begin
          o_wena_cyc = c; o_wena_addr = bus.mem_addr; o_wena_data = bus.mem_wdata;
        end
        o_wena_cnt++;
      end
      if (bus.rsp_valid) begin
        if (o_rsp_cnt == 0) begin
          o_rsp_cyc = c; o_rsp_err = bus.rsp_err; o_rsp_rdata = bus.rsp_rdata;
        end
        o_rsp_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_width = 2'b00; bus.req_sign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.req_ready); end
    total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b%b exp=00", bus.rsp_valid, bus.rsp_err); end
    total++; if (bus.mem_wena !== 1'b0 || bus.mem_addr !== 11'd0 || bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL reset_mem got=%b %h %h exp=0 0 0", bus.mem_wena, bus.mem_addr, bus.mem_wdata); end
    total++; if (bus.rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_word_store;
    int w0;
    w0 = wr_count;
    run_req(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 2'b10, 1'b0);
    total++; if (o_ready_t0 !== 1'b1 || o_ready_t1 !== 1'b0) begin bad++; $display("FAIL ws_ready got=%b%b exp=10", o_ready_t0, o_ready_t1); end
    total++; if (o_wena_cnt != 1 || o_wena_cyc != 1) begin bad++; $display("FAIL ws_wena got=cnt%0d cyc%0d exp=cnt1 cyc1", o_wena_cnt, o_wena_cyc); end
    total++; if (o_wena_addr !== 11'd1 || o_wena_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ws_write got=%h/%h exp=001/deadbeef", o_wena_addr, o_wena_data); end
    total++; if (o_rsp_cyc != 2 || o_rsp_cnt != 1 || o_rsp_err !== 1'b0) begin bad++; $display("FAIL ws_rsp got=cyc%0d cnt%0d err%b exp=cyc2 cnt1 err0", o_rsp_cyc, o_rsp_cnt, o_rsp_err); end
    total++; if (mem[1] !== 32'hDEAD_BEEF || wr_count - w0 != 1) begin bad++; $display("FAIL ws_mem got=%h/%0d exp=deadbeef/1", mem[1], wr_count - w0); end
  endtask

  task automatic test_byte_store;
    int w0;
    preload(11'd1, 32'h1122_3344);
    w0 = wr_count;
    run_req(1'b1, 32'h1001_0006, 32'h0000_00AB, 2'b00, 1'b0);
    total++; if (o_addr_t1 !== 11'd1) begin bad++; $display("FAIL bs_rd_addr got=%h exp=001", o_addr_t1); end
    total++; if (o_wena_cnt != 1 || o_wena_cyc != 3) begin bad++; $display("FAIL bs_wena got=cnt%0d cyc%0d exp=cnt1 cyc3", o_wena_cnt, o_wena_cyc); end
    total++; if (o_wena_addr !== 11'd1 || o_wena_data !== 32'h11AB_3344) begin bad++; $display("FAIL bs_write got=%h/%h exp=001/11ab3344", o_wena_addr, o_wena_data); end
    total++; if (o_rsp_cyc != 4 || o_rsp_err !== 1'b0) begin bad++; $display("FAIL bs_rsp got=cyc%0d err%b exp=cyc4 err0", o_rsp_cyc, o_rsp_err); end
    total++; if (wr_count - w0 != 1) begin bad++; $display("FAIL bs_wr_count got=%0d exp=1", wr_count - w0); end
  endtask

  task automatic test_byte_load;
    preload(11'd1, 32'h80FF_0000);
    run_req(1'b0, 32'h1001_0007, 32'h0, 2'b00, 1'b1);
    total++; if (o_rsp_cyc != 3 || o_rsp_err !== 1'b0) begin bad++; $display("FAIL bl_rsp got=cyc%0d err%b exp=cyc3 err0", o_rsp_cyc, o_rsp_err); end
    total++; if (o_rsp_rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL bl_sext got=%h exp=ffffff80", o_rsp_rdata); end
    total++; if (o_wena_cnt != 0) begin bad++; $display("FAIL bl_no_write got=%0d exp=0", o_wena_cnt); end
    run_req(1'b0, 32'h1001_0007, 32'h0, 2'b00, 1'b0);
    total++; if (o_rsp_rdata !== 32'h0000_0080) begin bad++; $display("FAIL bl_zext got=%h exp=00000080", o_rsp_rdata); end
    run_req(1'b0, 32'h1001_0005, 32'h0, 2'b00, 1'b1);
    total++; if (o_rsp_rdata !== 32'h0000_0000) begin bad++; $display("FAIL bl_lane1 got=%h exp=00000000", o_rsp_rdata); end
  endtask

  task automatic test_half;
    preload(11'd0, 32'h8001_ABCD);
    run_req(1'b0, 32'h1001_0002, 32'h0, 2'b01, 1'b1);
    total++; if (o_rsp_cyc != 3 || o_rsp_rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL hl_hi got=cyc%0d %h exp=cyc3 ffff8001", o_rsp_cyc, o_rsp_rdata); end
    run_req(1'b0, 32'h1001_0000, 32'h0, 2'b01, 1'b0);
    total++; if (o_rsp_rdata !== 32'h0000_ABCD) begin bad++; $display("FAIL hl_lo got=%h exp=0000abcd", o_rsp_rdata); end
    run_req(1'b1, 32'h1001_0000, 32'h0000_1234, 2'b01, 1'b0);
    total++; if (o_wena_cyc != 3 || o_wena_data !== 32'h8001_1234) begin bad++; $display("FAIL hs_write got=cyc%0d %h exp=cyc3 80011234", o_wena_cyc, o_wena_data); end
    total++; if (o_rsp_cyc != 4 || o_rsp_rdata !== 32'h0000_ABCD) begin bad++; $display("FAIL hs_rsp got=cyc%0d %h exp=cyc4 0000abcd", o_rsp_cyc, o_rsp_rdata); end
  endtask

  task automatic test_errors;
    run_req(1'b1, 32'h1001_0002, 32'h5555_5555, 2'b10, 1'b0);
    total++; if (o_rsp_cyc != 1 || o_rsp_err !== 1'b1 || o_wena_cnt != 0) begin bad++; $display("FAIL err_word_mis got=cyc%0d err%b w%0d exp=cyc1 err1 w0", o_rsp_cyc, o_rsp_err, o_wena_cnt); end
    total++; if (o_rsp_rdata !== 32'h0000_ABCD) begin bad++; $display("FAIL err_word_mis_rdata got=%h exp=0000abcd", o_rsp_rdata); end
    run_req(1'b0, 32'h1000_FFFC, 32'h0, 2'b10, 1'b0);
    total++; if (o_rsp_cyc != 1 || o_rsp_err !== 1'b1 || o_rsp_rdata !== 32'h0000_ABCD) begin bad++; $display("FAIL err_below got=cyc%0d err%b %h exp=cyc1 err1 0000abcd", o_rsp_cyc, o_rsp_err, o_rsp_rdata); end
    run_req(1'b0, 32'h1001_2000, 32'h0, 2'b10, 1'b0);
    total++; if (o_rsp_cyc != 1 || o_rsp_err !== 1'b1) begin bad++; $display("FAIL err_range got=cyc%0d err%b exp=cyc1 err1", o_rsp_cyc, o_rsp_err); end
    run_req(1'b1, 32'h1001_0001, 32'h0000_7777, 2'b01, 1'b0);
    total++; if (o_rsp_cyc != 1 || o_rsp_err !== 1'b1 || o_wena_cnt != 0) begin bad++; $display("FAIL err_half_odd got=cyc%0d err%b w%0d exp=cyc1 err1 w0", o_rsp_cyc, o_rsp_err, o_wena_cnt); end
    preload(11'h7FF, 32'hCAFE_F00D);
    run_req(1'b0, 32'h1001_1FFC, 32'h0, 2'b11, 1'b0);
    total++; if (o_rsp_cyc != 3 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL last_word got=cyc%0d err%b %h exp=cyc3 err0 cafef00d", o_rsp_cyc, o_rsp_err, o_rsp_rdata); end
  endtask

  task automatic test_reset_mid;
    int w0, wena_seen, rsp_seen;
    w0 = wr_count; wena_seen = 0; rsp_seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h1001_0002;
    bus.req_wdata = 32'h0000_5555; bus.req_width = 2'b01; bus.req_sign = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (bus.mem_wena) wena_seen++;
    if (bus.rsp_valid) rsp_seen++;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.mem_wena) wena_seen++;
      if (bus.rsp_valid) rsp_seen++;
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    if (bus.mem_wena) wena_seen++;
    if (bus.rsp_valid) rsp_seen++;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", bus.req_ready); end
    total++; if (wena_seen != 0 || wr_count - w0 != 0) begin bad++; $display("FAIL rm_no_write got=%0d/%0d exp=0/0", wena_seen, wr_count - w0); end
    total++; if (rsp_seen != 0) begin bad++; $display("FAIL rm_no_rsp got=%0d exp=0", rsp_seen); end
    run_req(1'b0, 32'h1001_0000, 32'h0, 2'b10, 1'b0);
    total++; if (o_rsp_cyc != 3 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'h8001_1234) begin bad++; $display("FAIL rm_reload got=cyc%0d err%b %h exp=cyc3 err0 80011234", o_rsp_cyc, o_rsp_err, o_rsp_rdata); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_store();
    test_byte_load();
    test_half();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sequential load/store engine between the pipelined CPU's memory stage and the synchronous-read DMEM.
- Replaces the combinational sub-word cut/merge path with a multi-cycle FSM:
  - word stores write directly;
  - loads read, extract and sign/zero-extend;
  - byte/half stores do a read-modify-write so unaffected lanes are preserved.
- Also translates byte addresses to DMEM word indices and flags misaligned or out-of-range accesses.

Parameters:
- BASE_ADDR, 32'h10010000, byte address that maps to DMEM word 0.
- IDX_W, 11, DMEM word-index width (depth = 2^IDX_W words).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is right-aligned in the low bits for byte/half.
- req_width  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- req_sign  in  1  loads only: 1 sign-extend, 0 zero-extend.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result, registered.
- rsp_err  out  1  qualifies rsp_valid: access rejected.
- mem_addr  out  IDX_W  DMEM word index.
- mem_wena  out  1  DMEM write enable.
- mem_wdata  out  32  DMEM write word.
- mem_rdata  in  32  DMEM read word, valid the cycle after mem_addr is presented.

Behaviour:
- Reset (asynchronous):
  - State returns to IDLE; all registers cleared.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wena=0, mem_addr=0, mem_wdata=0.
  - req_ready=0 while rst is high, 1 in the first cycle after release.
- States: IDLE, RD, MRG, WR, RSP.
- Output decode:
  - mem_wena is decoded from state WR only, so an asynchronous reset kills a pending write immediately.
  - req_ready = (state==IDLE) and not rst.
- Handshake and capture:
  - Accept happens when req_valid and req_ready are both 1 (cycle T).
  - On accept, latch we, addr, wdata, width and sign.
  - A new request is accepted only in IDLE; back-to-back requests therefore cost full latency each.
- Index: idx = (req_addr - BASE_ADDR) >> 2, truncated to IDX_W bits.
- Error condition:
  - half with addr[0]=1;
  - word with addr[1:0] != 0;
  - addr < BASE_ADDR;
  - (addr - BASE_ADDR) >> 2 >= 2^IDX_W.
  - On error: IDLE -> RSP, no DMEM access; rsp_valid=1, rsp_err=1, rsp_rdata unchanged; response at T+1.
- Transitions out of IDLE:
  - word store -> WR;
  - load or byte/half store -> RD.
- RD: mem_addr=idx, mem_wena=0; always -> MRG.
- MRG: mem_rdata is valid.
  - Load: extract the lane, extend, latch into rsp_rdata; -> RSP.
  - Store: latch the merged word; -> WR.
- WR: mem_addr=idx, mem_wena=1 for exactly one cycle, mem_wdata = full wdata (word) or merged word (sub-word); -> RSP.
- RSP: rsp_valid=1 for one cycle, rsp_err=0; -> IDLE.
- Lane rules (little-endian, lane = addr[1:0]):
  - byte k occupies bits [8k+7:8k];
  - half occupies bits [16*addr[1]+15 : 16*addr[1]];
  - merge replaces only the addressed lane with req_wdata[7:0] or req_wdata[15:0].
- Latency:
  - word store: rsp at T+2;
  - load: rsp at T+3;
  - byte/half store: rsp at T+4;
  - error: rsp at T+1.
- rsp_rdata is updated only on a successful load and holds its value otherwise; it is unchanged by stores.
- req_* inputs are ignored outside IDLE; the latched copy is used.
- Reset in any state:
  - abort, no DMEM write issued after reset assertion, no rsp_valid for the aborted request;
  - after release the unit is in IDLE, ready.

Test Plan:
- Word store 0xDEADBEEF @0x10010004: mem_wena=1 with mem_addr=1 and mem_wdata=0xDEADBEEF at T+1 only; rsp_valid=1, rsp_err=0 at T+2.
- Byte store wdata=0x000000AB @0x10010006, DMEM word1=0x11223344: RD at T+1, mem_wena at T+3 with mem_wdata=0x11AB3344; rsp at T+4; no other write.
- Byte load @0x10010007, word1=0x80FF0000: sign=1 gives rsp_rdata=0xFFFFFF80 at T+3; sign=0 gives 0x00000080.
- Half load sign=1 @0x10010002, word0=0x8001ABCD: rsp_rdata=0xFFFF8001; half store 0x1234 @0x10010000 gives written word 0x80011234.
- Errors: word store @0x10010002 gives no mem_wena and rsp_valid=rsp_err=1 at T+1. Load @0x1000FFFC gives the same response, and rsp_rdata keeps its previous value.
- Reset mid-op: half store accepted, rst raised during MRG. Required: mem_wena never asserts, no rsp_valid, and req_ready=1 the cycle after rst falls. A following word load returns the original DMEM contents.
